// File: rtl/pooling_pkg.sv
// Shared types and sizing for the pooling row buffer.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package pooling_pkg;

  localparam int DATA_WIDTH    = `DATA_WIDTH;
  localparam int OUTPUT_SIZE   = 3;
  localparam int TOTAL_FEATURE = 4;
  localparam int FEATURE_WIDTH = 2;
  localparam int ROW_WIDTH     = 3;
  localparam int FIFO_DEPTH    = 4;

  localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);
  localparam int FIFO_CNT_W = FIFO_PTR_W + 1;
  // Column counter must also hold OUTPUT_SIZE=1 without a zero-width vector.
  localparam int COL_W      = $clog2(OUTPUT_SIZE + 1);

  typedef logic [DATA_WIDTH-1:0] pool_data_t;

  // Column 0 sits in the most significant slice.
  typedef struct packed {
    logic [FEATURE_WIDTH-1:0]     feature_idx;
    logic [ROW_WIDTH-1:0]         feature_row;
    pool_data_t [0:OUTPUT_SIZE-1] data;
  } row_entry_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } asm_state_t;

endpackage

// File: rtl/pooling_row_buffer_if.sv
// Input beat bus and output row handshake of the pooling row buffer.
interface pooling_row_buffer_if;
  import pooling_pkg::*;

  logic                              input_valid;
  logic [FEATURE_WIDTH-1:0]          feature_idx;
  logic [ROW_WIDTH-1:0]              feature_row;
  logic [DATA_WIDTH-1:0]             data_in;

  logic                              out_valid;
  logic                              out_ready;
  logic [FEATURE_WIDTH-1:0]          out_feature_idx;
  logic [ROW_WIDTH-1:0]              out_feature_row;
  logic [OUTPUT_SIZE*DATA_WIDTH-1:0] data_out;
  logic                              frame_done;
  logic                              overflow;
  logic                              tag_error;

  modport slave (
    input  input_valid, feature_idx, feature_row, data_in, out_ready,
    output out_valid, out_feature_idx, out_feature_row, data_out,
           frame_done, overflow, tag_error
  );

  modport master (
    output input_valid, feature_idx, feature_row, data_in, out_ready,
    input  out_valid, out_feature_idx, out_feature_row, data_out,
           frame_done, overflow, tag_error
  );

endinterface

// File: rtl/pooling_row_fifo.sv
// Generic first-word-fall-through FIFO of packed entries.
module pooling_row_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign pop_ok  = pop & ~empty;
  // When full, a same-cycle pop frees the slot the write lands in.
  assign push_ok = push & (~full | pop_ok);

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

  // Next storage, pointer and occupancy; pointers wrap by power-of-two width.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  // Register FIFO state with synchronous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/pooling_row_buffer.sv
// Packs pooled scalars into tagged rows, queues them and hands them downstream.
//
// state      | meaning
// ST_IDLE    | no partial row held; next valid beat becomes column 0
// ST_COLLECT | partial row held; col_q is the next column to fill
module pooling_row_buffer
  import pooling_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  pooling_row_buffer_if.slave  bus
);

  asm_state_t                   state_q, state_d;
  logic [COL_W-1:0]             col_q, col_d;
  logic [FEATURE_WIDTH-1:0]     tag_fi_q, tag_fi_d;
  logic [ROW_WIDTH-1:0]         tag_row_q, tag_row_d;
  pool_data_t [0:OUTPUT_SIZE-1] row_q, row_d;
  logic                         overflow_q, overflow_d;
  logic                         tag_error_q, tag_error_d;
  logic                         frame_done_q, frame_done_d;

  logic                         row_push;
  logic [COL_W-1:0]             pos;
  logic                         tag_mismatch;
  row_entry_t                   push_entry;
  row_entry_t                   head;
  logic                         fifo_full, fifo_empty;
  logic [FIFO_CNT_W-1:0]        fifo_count;
  logic                         out_valid;
  logic                         pop;

  assign out_valid    = (fifo_count != '0);
  assign pop          = ~fifo_empty & bus.out_ready;
  assign tag_mismatch = (bus.feature_idx != tag_fi_q) || (bus.feature_row != tag_row_q);

  // Row assembly: place the beat, detect completion, restart on a tag change.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    tag_fi_d    = tag_fi_q;
    tag_row_d   = tag_row_q;
    row_d       = row_q;
    tag_error_d = tag_error_q;
    row_push    = 1'b0;
    pos         = '0;
    if (bus.input_valid) begin
      if (state_q == ST_IDLE || tag_mismatch) begin
        if (state_q == ST_COLLECT) begin
          tag_error_d = 1'b1;
        end
        row_d     = '0;
        tag_fi_d  = bus.feature_idx;
        tag_row_d = bus.feature_row;
      end else begin
        pos = col_q;
      end
      row_d[pos] = bus.data_in;
      if (pos == COL_W'(OUTPUT_SIZE - 1)) begin
        row_push = 1'b1;
        col_d    = '0;
        state_d  = ST_IDLE;
      end else begin
        col_d    = pos + COL_W'(1);
        state_d  = ST_COLLECT;
      end
    end
  end

  // Completed row entry and the status flags that depend on the FIFO.
  always_comb begin
    push_entry.feature_idx = tag_fi_d;
    push_entry.feature_row = tag_row_d;
    push_entry.data        = row_d;
    overflow_d   = overflow_q | (row_push & fifo_full & ~pop);
    frame_done_d = pop &&
                   (head.feature_idx == FEATURE_WIDTH'(TOTAL_FEATURE - 1)) &&
                   (head.feature_row == ROW_WIDTH'(OUTPUT_SIZE - 1));
  end

  // Assembler FSM and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      tag_fi_q     <= '0;
      tag_row_q    <= '0;
      row_q        <= '0;
      overflow_q   <= 1'b0;
      tag_error_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      tag_fi_q     <= tag_fi_d;
      tag_row_q    <= tag_row_d;
      row_q        <= row_d;
      overflow_q   <= overflow_d;
      tag_error_q  <= tag_error_d;
      frame_done_q <= frame_done_d;
    end
  end

  pooling_row_fifo #(
    .WIDTH ($bits(row_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (row_push),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.out_valid       = out_valid;
  assign bus.out_feature_idx = head.feature_idx;
  assign bus.out_feature_row = head.feature_row;
  assign bus.data_out        = head.data;
  assign bus.frame_done      = frame_done_q;
  assign bus.overflow        = overflow_q;
  assign bus.tag_error       = tag_error_q;

endmodule

// File: tb/tb_pooling_row_buffer.sv
// Bench for pooling_row_buffer: vector table, scoreboard of queued rows, corner sequences.
module tb_pooling_row_buffer;
  import pooling_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pooling_row_buffer_if bus();

  pooling_row_buffer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [1:0]  fi;
    logic [2:0]  row;
    logic [95:0] data;
  } exp_t;

  typedef struct {
    logic [1:0]  fi;
    logic [2:0]  row;
    logic [31:0] v0, v1, v2;
    logic [95:0] exp;
  } vec_t;

  exp_t         sb[$];
  vec_t         vecs[6];
  int           n_vec = 0;
  int           n_err = 0;
  logic         fd_exp = 1'b0;
  int           fd_count = 0;
  logic         hold_prev = 1'b0;
  logic [101:0] hold_val = '0;
  logic         rand_ready = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: monitor at the falling edge, then step past the rising edge.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      fd_exp    = 1'b0;
      hold_prev = 1'b0;
    end else begin
      if (fd_exp || bus.frame_done) chk("frame_done", bus.frame_done, fd_exp);
      if (bus.frame_done) fd_count++;
      fd_exp = 1'b0;
      if (hold_prev)
        chk("hold_stable", {bus.out_valid, bus.out_feature_idx, bus.out_feature_row, bus.data_out}, hold_val);
      hold_prev = bus.out_valid && !bus.out_ready;
      hold_val  = {bus.out_valid, bus.out_feature_idx, bus.out_feature_row, bus.data_out};
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_row", bus.out_valid, 1'b0);
        end else begin
          e = sb.pop_front();
          chk("row_tag", {bus.out_feature_idx, bus.out_feature_row}, {e.fi, e.row});
          chk("row_data", bus.data_out, e.data);
          if (e.fi == 2'd3 && e.row == 3'd2) fd_exp = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic beat(input logic [1:0] fi, input logic [2:0] r, input logic [31:0] v);
    bus.input_valid = 1'b1;
    bus.feature_idx = fi;
    bus.feature_row = r;
    bus.data_in     = v;
    cyc();
    bus.input_valid = 1'b0;
  endtask

  // A complete row is queued only if the FIFO had room after this cycle's pop.
  task automatic send_row(input logic [1:0] fi, input logic [2:0] r,
                          input logic [31:0] v0, input logic [31:0] v1, input logic [31:0] v2);
    beat(fi, r, v0);
    beat(fi, r, v1);
    beat(fi, r, v2);
    if (sb.size() < FIFO_DEPTH) sb.push_back('{fi: fi, row: r, data: {v0, v1, v2}});
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 200 && sb.size() != 0; i++) cyc();
    chk("drain_done", sb.size(), 0);
    chk("drained_valid", bus.out_valid, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.input_valid = 1'b0;
    cyc();
    rst_n = 1'b1;
    sb.delete();
    hold_prev = 1'b0;
    fd_exp    = 1'b0;
  endtask

  task automatic check_reset();
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_data_out", bus.data_out, 96'h0);
    chk("rst_fi", bus.out_feature_idx, 2'd0);
    chk("rst_row", bus.out_feature_row, 3'd0);
    chk("rst_frame_done", bus.frame_done, 1'b0);
    chk("rst_overflow", bus.overflow, 1'b0);
    chk("rst_tag_error", bus.tag_error, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'd0, 3'd0, 32'h3F800000, 32'h40000000, 32'h40400000, 96'h3F800000_40000000_40400000};
    vecs[1] = '{2'd1, 3'd1, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 96'hFFFFFFFF_00000000_FFFFFFFF};
    vecs[2] = '{2'd2, 3'd2, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 96'h12345678_9ABCDEF0_0F0F0F0F};
    vecs[3] = '{2'd3, 3'd1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 96'h80000000_00000001_7FFFFFFF};
    vecs[4] = '{2'd0, 3'd7, 32'hDEADBEEF, 32'hCAFEF00D, 32'h00C0FFEE, 96'hDEADBEEF_CAFEF00D_00C0FFEE};
    vecs[5] = '{2'd3, 3'd0, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h00000000, 96'hA5A5A5A5_5A5A5A5A_00000000};

    bus.input_valid = 1'b0;
    bus.feature_idx = '0;
    bus.feature_row = '0;
    bus.data_in     = '0;
    bus.out_ready   = 1'b0;

    do_reset();
    check_reset();

    // Straight row with latency and single-beat output.
    bus.out_ready = 1'b1;
    beat(2'd0, 3'd0, 32'h3F800000);
    beat(2'd0, 3'd0, 32'h40000000);
    chk("pre_valid", bus.out_valid, 1'b0);
    beat(2'd0, 3'd0, 32'h40400000);
    sb.push_back('{fi: 2'd0, row: 3'd0, data: 96'h3F800000_40000000_40400000});
    chk("lat_valid", bus.out_valid, 1'b1);
    chk("lat_data", bus.data_out, 96'h3F800000_40000000_40400000);
    cyc();
    chk("one_beat", bus.out_valid, 1'b0);

    // Table of rows with out_ready held high.
    for (int i = 0; i < 6; i++) begin
      send_row(vecs[i].fi, vecs[i].row, vecs[i].v0, vecs[i].v1, vecs[i].v2);
      chk("vec_valid", bus.out_valid, 1'b1);
      chk("vec_data", bus.data_out, vecs[i].exp);
      chk("vec_tag", {bus.out_feature_idx, bus.out_feature_row}, {vecs[i].fi, vecs[i].row});
    end
    drain();

    // Back-pressure: four rows fill the FIFO, the fifth is dropped.
    do_reset();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++)
      send_row(2'(k), 3'(k % 3), 32'h1100_0000 + k, 32'h2200_0000 + k, 32'h3300_0000 + k);
    chk("bp_no_ovf", bus.overflow, 1'b0);
    chk("bp_valid", bus.out_valid, 1'b1);
    chk("bp_head", bus.data_out, 96'h11000000_22000000_33000000);
    send_row(2'd1, 3'd1, 32'hBAD0_0001, 32'hBAD0_0002, 32'hBAD0_0003);
    chk("bp_ovf", bus.overflow, 1'b1);
    chk("bp_sb_size", sb.size(), 4);
    drain();
    chk("bp_ovf_sticky", bus.overflow, 1'b1);

    // Full FIFO with a pop in the same cycle the fifth row completes.
    do_reset();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++)
      send_row(2'(k), 3'd2, 32'h4400_0000 + k, 32'h5500_0000 + k, 32'h6600_0000 + k);
    beat(2'd2, 3'd1, 32'h7700_0001);
    beat(2'd2, 3'd1, 32'h7700_0002);
    bus.out_ready = 1'b1;
    beat(2'd2, 3'd1, 32'h7700_0003);
    sb.push_back('{fi: 2'd2, row: 3'd1, data: 96'h77000001_77000002_77000003});
    chk("fp_no_ovf", bus.overflow, 1'b0);
    drain();
    chk("fp_no_ovf_end", bus.overflow, 1'b0);

    // Tag change in the middle of a row.
    bus.out_ready = 1'b1;
    beat(2'd1, 3'd2, 32'hEEEE_0001);
    beat(2'd1, 3'd2, 32'hEEEE_0002);
    chk("te_clear", bus.tag_error, 1'b0);
    send_row(2'd1, 3'd0, 32'h0101_0101, 32'h0202_0202, 32'h0303_0303);
    chk("te_set", bus.tag_error, 1'b1);
    drain();

    // Reset with two queued rows and a partial row.
    bus.out_ready = 1'b0;
    send_row(2'd2, 3'd0, 32'hAAAA_0000, 32'hAAAA_0001, 32'hAAAA_0002);
    send_row(2'd2, 3'd1, 32'hBBBB_0000, 32'hBBBB_0001, 32'hBBBB_0002);
    beat(2'd2, 3'd2, 32'hCCCC_0000);
    beat(2'd2, 3'd2, 32'hCCCC_0001);
    do_reset();
    check_reset();
    bus.out_ready = 1'b1;
    send_row(2'd2, 3'd2, 32'h1357_9BDF, 32'h2468_ACE0, 32'h0000_FFFF);
    chk("post_rst_data", bus.data_out, 96'h13579BDF_2468ACE0_0000FFFF);
    drain();

    // Whole frame with random back-pressure.
    fd_count   = 0;
    rand_ready = 1'b1;
    for (int f = 0; f < TOTAL_FEATURE; f++)
      for (int r = 0; r < OUTPUT_SIZE; r++)
        send_row(2'(f), 3'(r), 32'h1000_0000 | (f << 8) | (r << 4) | 0,
                 32'h1000_0000 | (f << 8) | (r << 4) | 1,
                 32'h1000_0000 | (f << 8) | (r << 4) | 2);
    rand_ready = 1'b0;
    drain();
    cyc();
    chk("frame_done_count", fd_count, 1);
    chk("frame_no_ovf", bus.overflow, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pooling_row_buffer.md
Name: pooling_row_buffer

Overview:
- Sits directly downstream of pooling_layer_top's output interface. Consumes one pooled scalar per valid beat, tagged with feature index and output row.
- Packs OUTPUT_SIZE consecutive scalars into one row word and queues complete rows in a small FIFO.
- Presents rows to the next convolution stage over a valid/ready handshake, and flags the end of each pooled frame.

Parameters:
- DATA_WIDTH, `DATA_WIDTH (global define): width of one pooled value.
- OUTPUT_SIZE, 3: pooled values per row.
- TOTAL_FEATURE, 4: feature maps per frame.
- FEATURE_WIDTH, 2: width of feature index.
- ROW_WIDTH, 3: width of row index.
- FIFO_DEPTH, 4: number of complete rows buffered; power of two, at least 2.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: reset; synchronous, active-low.
- input_valid, input, 1: data_in, feature_idx and feature_row are valid this cycle.
- feature_idx, input, FEATURE_WIDTH: feature of the incoming value.
- feature_row, input, ROW_WIDTH: pooled row of the incoming value.
- data_in, input, DATA_WIDTH: one pooled value, left-most column first.
- out_valid, output, 1: FIFO head row is valid.
- out_ready, input, 1: consumer accepts the head row.
- out_feature_idx, output, FEATURE_WIDTH: tag of the head row.
- out_feature_row, output, ROW_WIDTH: tag of the head row.
- data_out, output, OUTPUT_SIZE*DATA_WIDTH: column 0 in the MSB slice; same slice order as data_in buses elsewhere.
- frame_done, output, 1: one-cycle pulse when the row tagged (TOTAL_FEATURE-1, OUTPUT_SIZE-1) is popped.
- overflow, output, 1: sticky; a completed row was dropped.
- tag_error, output, 1: sticky; the tag changed mid-row.

Behaviour:
- Reset is synchronous: on the clk edge with rst_n=0, all state clears. Values after reset:
  - out_valid=0, frame_done=0, overflow=0, tag_error=0.
  - data_out=0, out_feature_idx=0, out_feature_row=0.
  - FIFO pointers, count and column counter = 0.
  - Reset mid-row discards the partial row. Reset with the FIFO non-empty discards all queued rows.
- Assembler, states IDLE and COLLECT:
  - IDLE + input_valid: store data_in in column 0, latch the tag, col=1, go to COLLECT.
  - COLLECT + input_valid with a matching tag: store data_in in column col, col++.
  - When col reaches OUTPUT_SIZE-1 and input_valid: the row is complete. Push {tag, row} this cycle, col=0, go to IDLE.
  - COLLECT + input_valid with a different tag: set tag_error, discard the partial row, restart at column 0 with the new tag. No push occurs.
  - No input_valid: hold state; no timeout.
  - OUTPUT_SIZE=1 degenerates to a push on every valid beat.
- FIFO:
  - First-word-fall-through; data_out and the tags are driven from the head entry register.
  - pop = out_valid & out_ready. out_valid = (count != 0).
  - Push when the row completes and (count < FIFO_DEPTH or pop this cycle). Pushing while full with a same-cycle pop is legal; count is unchanged.
  - Push while full without a pop: drop the row, set overflow, leave FIFO contents intact.
  - Pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH (needs log2(FIFO_DEPTH)+1 bits).
- Latency:
  - Last column accepted at edge N with the FIFO empty → out_valid=1 after edge N (visible in cycle N+1).
  - Pop at edge M → next entry (if any) visible in cycle M+1.
- frame_done:
  - Registered; asserted in the cycle after a pop of the tag (TOTAL_FEATURE-1, OUTPUT_SIZE-1).
  - The row index is the pooled-map row; the map is OUTPUT_SIZE×OUTPUT_SIZE.
- Stable outputs: data_out, tags and out_valid must not change while out_valid=1 and out_ready=0.
- Data is treated as opaque bits; no arithmetic is performed on it.

Decomposition:
- Shared package (pooling_pkg): DATA_WIDTH alias, the row-entry struct {feature_idx, feature_row, data[OUTPUT_SIZE]}, and localparam helpers (clog2 of FIFO_DEPTH).
- One natural sub-module: pooling_row_fifo. It is a generic FWFT FIFO of packed entries, with synchronous active-low reset and full/empty/count. The top holds the assembler FSM, the sticky flags and frame_done.

Test Plan:
- Straight row: tag (0,0) with values 0x3F800000, 0x40000000, 0x40400000, out_ready=1 → one beat, data_out = {1.0, 2.0, 3.0}, tag (0,0), out_valid high for exactly 1 cycle, arriving one cycle after the third input.
- Back-pressure: out_ready=0 while 4 rows are pushed → count=4, head stable. A fifth row completes → overflow=1 and the 4 original rows emerge in order once out_ready=1.
- Full with simultaneous pop: FIFO full, fifth row completes in the same cycle out_ready=1 → no overflow; 5 rows are delivered in order.
- Tag change mid-row: tag (1,2) for 2 values, then tag (1,0) for 3 values → tag_error=1, a single row with tag (1,0) is output, and the partial (1,2) values never appear.
- Full frame: 4 features × 3 rows × 3 values, out_ready toggling randomly → 12 rows in order; frame_done pulses once, on the cycle after row (3,2) pops.
- Reset mid-operation: rst_n=0 for 1 cycle with 2 queued rows and a partial row → all outputs at reset values. A new row afterwards is delivered correctly, with no stale data.
